// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the restoring divider.
//   state_e          - controller states
//   DEFAULT_WIDTH    - default operand/result width
//   cnt_width()      - iteration counter width for a given operand width
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Counter must be able to represent WIDTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 32'($clog2(w)) + 32'd1;
    endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// ripple_subtractor: combinational ripple-borrow subtractor, diff = a - b.
//   minuend_i    in  WIDTH  a
//   subtrahend_i in  WIDTH  b
//   diff         out WIDTH  a - b (modulo 2^WIDTH)
//   borrow_out   out 1      set when b > a
module ripple_subtractor #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] minuend_i,
    input  logic [WIDTH-1:0] subtrahend_i,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] borrow;

    // Chain of full-subtractor cells, LSB first.
    always_comb begin
        borrow[0] = 1'b0;
        diff      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]     = minuend_i[i] ^ subtrahend_i[i] ^ borrow[i];
            borrow[i+1] = (~minuend_i[i] & subtrahend_i[i])
                        | (~(minuend_i[i] ^ subtrahend_i[i]) & borrow[i]);
        end
    end

    assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring shift-and-subtract divider.
// One iteration per cycle; results and div_by_zero update only on the edge
// that raises done and are held until the next result.
// Optional macro RESTORING_DIVIDER_SIGNED_EN selects two's-complement
// operands (magnitude core with combinational sign fix-up); undefined is
// unsigned only.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   request, accepted only while busy=0
//   dividend    in   WIDTH numerator, sampled with an accepted start
//   divisor     in   WIDTH denominator, sampled with an accepted start
//   busy        out  operation in progress
//   done        out  one-cycle pulse, results valid
//   quotient    out  WIDTH result
//   remainder   out  WIDTH result
//   div_by_zero out  divisor was zero
module restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;       // partial remainder
    logic [WIDTH-1:0]   q_q, q_d;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   d_q, d_d;       // divisor magnitude
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [WIDTH-1:0]   q_res, r_res;
    logic [WIDTH:0]     trial_a, trial_b, trial_diff;
    logic               trial_borrow;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic negq_q, negq_d, negr_q, negr_d;
    logic accept;

    assign accept  = (state_q == IDLE) && start;
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + ONE_W) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + ONE_W)  : divisor;
    assign negq_d  = accept ? (dividend[WIDTH-1] ^ divisor[WIDTH-1]) : negq_q;
    assign negr_d  = accept ? dividend[WIDTH-1] : negr_q;
    // Most-negative dividend has magnitude 2^(WIDTH-1), which is still
    // exact as an unsigned WIDTH-bit value, so -2^(W-1)/-1 needs no special case.
    assign q_res   = negq_q ? (~q_q + ONE_W) : q_q;
    assign r_res   = negr_q ? (~r_q + ONE_W) : r_q;

    // Result sign bits captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = q_q;
    assign r_res   = r_q;
`endif

    // Shifted partial remainder (WIDTH+1 bits) against the zero-extended divisor.
    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    ripple_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .minuend_i    (trial_a),
        .subtrahend_i (trial_b),
        .diff         (trial_diff),
        .borrow_out   (trial_borrow)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    d_d    = dvs_mag;
                    q_d    = dvd_mag;
                    // Zero path parks the raw dividend in r_q as its remainder.
                    r_d    = (divisor == '0) ? dividend : '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    state_d = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (trial_borrow) begin
                    r_d = trial_a[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial_diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            ZERO: begin
                busy_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (d_q == '0) begin
                    quot_d = '1;
                    rem_d  = r_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = q_res;
                    rem_d  = r_res;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
